// File: rtl/async_fifo_pkg.sv
// Types and constants shared by the async FIFO write-side blocks.
package async_fifo_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// searching circularly so NUM_REQ need not be a power of two.
module rr_arbiter_core
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int CAND_W = IDX_W + 1;
  localparam logic [CAND_W-1:0] NUM_REQ_W = CAND_W'(NUM_REQ);

  logic [CAND_W-1:0] cand;
  logic              found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr < NUM_REQ and i < NUM_REQ, so one subtraction wraps the sum.
      cand = {1'b0, rr_ptr} + CAND_W'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                          = 1'b1;
        grant_idx                      = cand[IDX_W-1:0];
        grant_onehot[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port among NUM_REQ
// producers in the wr_clk domain; one idle arbitration cycle separates bursts.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_WIDTH    = 16,
  parameter  int MAX_BURST     = 8,
  parameter  int USE_PROG_FULL = 1,
  localparam int IDX_W         = clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic [STALL_CNT_W-1:0]        stall_cnt
);

  localparam logic [7:0]             MAX_BEATS      = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0]       LAST_IDX       = IDX_W'(NUM_REQ - 1);
  localparam bit                     GATE_PROG_FULL = (USE_PROG_FULL != 0);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX      = '1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [NUM_REQ-1:0]      arb_onehot;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any, eligible, in_burst;
  logic                    gnt_valid, gnt_last, accept, burst_end;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_core (
    .req          (req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Handshake: a beat of requester i transfers when req_valid[i] and
  // req_ready[i] are both high at a wr_clk edge; ready is offered only to the
  // granted requester during BURST and only while the FIFO is not full.
  assign arb_any      = |arb_onehot;
  assign eligible     = arb_any && !(GATE_PROG_FULL && fifo_prog_full);
  assign in_burst     = (state_q == ST_BURST);
  assign gnt_valid    = req_valid[grant_id_q];
  assign gnt_last     = req_last[grant_id_q];
  assign accept       = in_burst && gnt_valid && !fifo_full;
  assign beat_cnt_inc = beat_cnt_q + 8'd1;
  assign burst_end    = in_burst && !fifo_full &&
                        (!gnt_valid || gnt_last || (beat_cnt_inc == MAX_BEATS));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          grant_id_d = arb_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) beat_cnt_d = beat_cnt_inc;
        if (fifo_full && (stall_cnt_q != STALL_MAX)) begin
          stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        if (burst_end) begin
          rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (in_burst) req_ready[grant_id_q] = !fifo_full;
  end

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = data_arr[grant_id_q];
  assign grant_id     = grant_id_q;
  assign busy         = in_burst;
  assign stall_cnt    = stall_cnt_q;

  a_no_write_when_full: assert property (
    @(posedge wr_clk) disable iff (!wr_rst_n) !(fifo_wr_en && fifo_full)
  );

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: per-cycle behavioural model plus an
// ordered write scoreboard loaded with hand-computed FIFO data for every phase.
module tb_async_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int MB  = 8;
  localparam int UPF = 1;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic              fifo_prog_full;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       stall_cnt;

  async_fifo_wr_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .MAX_BURST     (MB),
    .USE_PROG_FULL (UPF)
  ) dut (
    .wr_clk         (clk),
    .wr_rst_n       (rst_n),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .stall_cnt      (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester sources ----------------
  bit [NR-1:0]  src_en;
  int           sent [NR];
  int           limit [NR];
  int           last_every [NR];
  logic [NR-1:0] hs;

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = src_en[i] && (sent[i] < limit[i]);
      req_last[i]  = 1'b0;
      if (last_every[i] != 0) req_last[i] = (((sent[i] + 1) % last_every[i]) == 0);
      req_data[i*DW +: DW] = {4'(i), 12'(sent[i])};
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NR; i++) begin
      src_en[i] = 1'b0; sent[i] = 0; limit[i] = 0; last_every[i] = 0;
    end
  endtask

  task automatic set_src(input int i, input int lim, input int le);
    src_en[i] = 1'b1; sent[i] = 0; limit[i] = lim; last_every[i] = le;
  endtask

  task automatic push_range(input int id, input int from, input int to);
    for (int s = from; s <= to; s++) exp_q.push_back({4'(id), 12'(s)});
  endtask

  // One cycle: note handshakes, pass the edge, advance sources after it.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) sent[i]++;
      apply_inputs();
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  int m_busy, m_gid, m_ptr, m_beats, m_stall, idx;
  logic [NR-1:0] e_ready;
  logic          e_wen;
  logic [DW-1:0] e_data, e_wr;

  initial begin
    m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_stall = 0; idx = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
    end
    e_ready = '0;
    e_wen   = 1'b0;
    e_data  = req_data[m_gid*DW +: DW];
    if (m_busy != 0) begin
      e_ready[m_gid] = !fifo_full;
      e_wen          = req_valid[m_gid] && !fifo_full;
    end
    check("busy",      32'(busy),         32'(m_busy));
    check("grant_id",  32'(grant_id),     32'(m_gid));
    check("stall_cnt", 32'(stall_cnt),    32'(m_stall));
    check("req_ready", 32'(req_ready),    32'(e_ready));
    check("wr_en",     32'(fifo_wr_en),   32'(e_wen));
    check("wr_data",   32'(fifo_wr_data), 32'(e_data));

    if (fifo_wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_order: actual=%0h required=none (unexpected write, t=%0t)", fifo_wr_data, $time);
      end else begin
        e_wr = exp_q.pop_front();
        check("wr_order", 32'(fifo_wr_data), 32'(e_wr));
      end
    end

    // Advance the model to the state that follows the coming edge.
    if (rst_n) begin
      if (m_busy == 0) begin
        if ((req_valid != '0) && !((UPF != 0) && fifo_prog_full)) begin
          for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (req_valid[idx] && (m_busy == 0)) begin
              m_gid = idx; m_busy = 1; m_beats = 0;
            end
          end
        end
      end else if (fifo_full) begin
        if (m_stall < 65535) m_stall++;
      end else if (!req_valid[m_gid]) begin
        m_ptr = (m_gid + 1) % NR; m_busy = 0;
      end else begin
        m_beats++;
        if (req_last[m_gid] || (m_beats == MB)) begin
          m_ptr = (m_gid + 1) % NR; m_busy = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; fifo_full = 1'b0; fifo_prog_full = 1'b0;
    clear_srcs();
    apply_inputs();
    run(3);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_gid",   32'(grant_id),   32'd0);
    check("rst_stall", 32'(stall_cnt),  32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Round-robin: all four valid, last on every 2nd beat.
    for (int i = 0; i < NR; i++) set_src(i, 4, 2);
    apply_inputs();
    wr_count = 0;
    for (int i = 0; i < NR; i++) push_range(i, 0, 1);
    for (int i = 0; i < NR; i++) push_range(i, 2, 3);
    run(23);
    check("rr_pending", 32'(exp_q.size()), 32'd1);
    run(1);
    check("rr_empty",  32'(exp_q.size()), 32'd0);
    check("rr_writes", 32'(wr_count),     32'd16);
    check("rr_busy",   32'(busy),         32'd0);
    check("rr_gid",    32'(grant_id),     32'd3);

    // MAX_BURST: req 2 never sets last, req 3 has two beats.
    clear_srcs();
    set_src(2, 20, 0);
    set_src(3, 2, 0);
    apply_inputs();
    wr_count = 0;
    push_range(2, 0, 7); push_range(3, 0, 1); push_range(2, 8, 15); push_range(2, 16, 19);
    run(9);
    check("mb_writes8", 32'(wr_count), 32'd8);
    check("mb_idle",    32'(busy),     32'd0);
    check("mb_gid2",    32'(grant_id), 32'd2);
    run(1);
    check("mb_busy3", 32'(busy),     32'd1);
    check("mb_gid3",  32'(grant_id), 32'd3);
    run(25);
    check("mb_empty",  32'(exp_q.size()), 32'd0);
    check("mb_writes", 32'(wr_count),     32'd22);

    // Full stall of 5 cycles mid-burst.
    clear_srcs();
    set_src(1, 6, 6);
    apply_inputs();
    wr_count = 0;
    push_range(1, 0, 5);
    run(3);
    fifo_full = 1'b1;
    run(5);
    check("st_stall",  32'(stall_cnt), 32'd5);
    check("st_writes", 32'(wr_count),  32'd2);
    check("st_busy",   32'(busy),      32'd1);
    check("st_ready",  32'(req_ready), 32'd0);
    fifo_full = 1'b0;
    run(6);
    check("st_empty",   32'(exp_q.size()), 32'd0);
    check("st_writes6", 32'(wr_count),     32'd6);
    check("st_idle",    32'(busy),         32'd0);

    // prog_full blocks a new grant but not an ongoing burst.
    clear_srcs();
    fifo_prog_full = 1'b1;
    set_src(0, 4, 4);
    apply_inputs();
    wr_count = 0;
    push_range(0, 0, 3); push_range(3, 0, 1);
    run(4);
    check("pf_nogrant", 32'(busy),     32'd0);
    check("pf_nowrite", 32'(wr_count), 32'd0);
    fifo_prog_full = 1'b0;
    run(2);
    fifo_prog_full = 1'b1;
    run(5);
    check("pf_burst_done", 32'(wr_count), 32'd4);
    check("pf_idle",       32'(busy),     32'd0);
    set_src(3, 2, 2);
    apply_inputs();
    run(3);
    check("pf_blocked", 32'(busy), 32'd0);
    fifo_prog_full = 1'b0;
    run(4);
    check("pf_writes", 32'(wr_count),     32'd6);
    check("pf_gid",    32'(grant_id),     32'd3);
    check("pf_empty",  32'(exp_q.size()), 32'd0);

    // Requester drop: req 1 drains after 3 beats, pointer moves to 2.
    clear_srcs();
    set_src(1, 3, 0);
    set_src(2, 2, 0);
    apply_inputs();
    wr_count = 0;
    push_range(1, 0, 2); push_range(2, 0, 1); push_range(0, 0, 0);
    run(5);
    set_src(0, 1, 0);
    apply_inputs();
    run(1);
    check("dr_writes3", 32'(wr_count), 32'd3);
    check("dr_gid2",    32'(grant_id), 32'd2);
    check("dr_busy",    32'(busy),     32'd1);
    run(8);
    check("dr_empty", 32'(exp_q.size()), 32'd0);
    check("dr_gid0",  32'(grant_id),     32'd0);
    check("dr_idle",  32'(busy),         32'd0);

    // Reset in the middle of a burst from requester 1.
    clear_srcs();
    for (int i = 0; i < NR; i++) set_src(i, 100, 0);
    apply_inputs();
    wr_count = 0;
    push_range(1, 0, 1); push_range(0, 0, 7);
    run(3);
    rst_n = 1'b0;
    #1;
    check("mr_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mr_ready", 32'(req_ready),  32'd0);
    check("mr_busy",  32'(busy),       32'd0);
    check("mr_gid",   32'(grant_id),   32'd0);
    check("mr_stall", 32'(stall_cnt),  32'd0);
    run(2);
    rst_n = 1'b1;
    check("mr_idle_after", 32'(busy), 32'd0);
    run(1);
    check("mr_busy0", 32'(busy),     32'd1);
    check("mr_gid0",  32'(grant_id), 32'd0);
    run(9);
    check("mr_writes", 32'(wr_count), 32'd10);
    check("mr_gid1",   32'(grant_id), 32'd1);
    clear_srcs();
    apply_inputs();
    run(3);
    check("mr_empty", 32'(exp_q.size()), 32'd0);
    check("mr_idle",  32'(busy),         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
